// File: rtl/cache_mem_arbiter_pkg.sv
// Shared constants and types for the cache-to-memory arbiter.
// Source ids double as round-robin pointer values and FIFO entries.
package cache_mem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_BITS = 28;

    localparam logic SRC_IC = 1'b0;
    localparam logic SRC_DC = 1'b1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_WDATA = 1'b1
    } arb_state_e;

    function automatic logic other_src(input logic src);
        return ~src;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit source ids for reads awaiting a memory response.
// Push is ignored when full and pop is ignored when empty.
module arb_id_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] ids;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = ids[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap by overflowing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                ids[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter joining the instruction and data caches onto one memory port,
// sequencing write-data beats and steering in-order read responses back to their source.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS       = 28,
    parameter int unsigned DATA_BITS       = 128,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic                               ic_req_valid,
    output logic                               ic_req_ready,
    input  logic [ADDR_BITS-1:0]               ic_req_addr,
    input  logic                               ic_req_rw,
    input  logic                               ic_req_data_valid,
    output logic                               ic_req_data_ready,
    input  logic [DATA_BITS-1:0]               ic_req_data_bits,
    input  logic [DATA_BITS/8-1:0]             ic_req_data_mask,
    output logic                               ic_resp_valid,
    output logic [DATA_BITS-1:0]               ic_resp_data,

    input  logic                               dc_req_valid,
    output logic                               dc_req_ready,
    input  logic [ADDR_BITS-1:0]               dc_req_addr,
    input  logic                               dc_req_rw,
    input  logic                               dc_req_data_valid,
    output logic                               dc_req_data_ready,
    input  logic [DATA_BITS-1:0]               dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0]             dc_req_data_mask,
    output logic                               dc_resp_valid,
    output logic [DATA_BITS-1:0]               dc_resp_data,

    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_BITS-1:0]               mem_req_addr,
    output logic                               mem_req_rw,
    output logic                               mem_req_data_valid,
    input  logic                               mem_req_data_ready,
    output logic [DATA_BITS-1:0]               mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]             mem_req_data_mask,
    input  logic                               mem_resp_valid,
    input  logic [DATA_BITS-1:0]               mem_resp_data,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_unexpected_resp
);

    arb_state_e state;
    logic       rr_ptr;
    logic       lock;
    logic       lock_src;
    logic       wr_owner;

    logic       winner;
    logic       win_valid;
    logic       win_rw;
    logic       in_idle;
    logic       in_wdata;
    logic       accept;
    logic       data_done;
    logic       resp_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;

    assign in_idle  = ~reset & (state == ARB_IDLE);
    assign in_wdata = ~reset & (state == ARB_WDATA);

    // A stalled grant stays locked so the address the memory saw cannot change under it.
    always_comb begin
        if (lock) begin
            winner = lock_src;
        end else if (ic_req_valid && dc_req_valid) begin
            winner = rr_ptr;
        end else if (dc_req_valid) begin
            winner = SRC_DC;
        end else begin
            winner = SRC_IC;
        end
    end

    assign win_valid    = (winner == SRC_DC) ? dc_req_valid : ic_req_valid;
    assign win_rw       = (winner == SRC_DC) ? dc_req_rw    : ic_req_rw;
    assign mem_req_addr = (winner == SRC_DC) ? dc_req_addr  : ic_req_addr;
    assign mem_req_rw   = win_rw;

    // A read with no response slot is held off; the other cache is not promoted in its place.
    assign mem_req_valid = in_idle & win_valid & ~(~win_rw & fifo_full);
    assign accept        = mem_req_valid & mem_req_ready;
    assign ic_req_ready  = accept & (winner == SRC_IC);
    assign dc_req_ready  = accept & (winner == SRC_DC);

    assign mem_req_data_valid = in_wdata &
                                ((wr_owner == SRC_DC) ? dc_req_data_valid : ic_req_data_valid);
    assign mem_req_data_bits  = (wr_owner == SRC_DC) ? dc_req_data_bits : ic_req_data_bits;
    assign mem_req_data_mask  = (wr_owner == SRC_DC) ? dc_req_data_mask : ic_req_data_mask;
    assign ic_req_data_ready  = in_wdata & (wr_owner == SRC_IC) & mem_req_data_ready;
    assign dc_req_data_ready  = in_wdata & (wr_owner == SRC_DC) & mem_req_data_ready;
    assign data_done          = mem_req_data_valid & mem_req_data_ready;

    assign resp_pop      = ~reset & mem_resp_valid & ~fifo_empty;
    assign ic_resp_valid = resp_pop & (fifo_head == SRC_IC);
    assign dc_resp_valid = resp_pop & (fifo_head == SRC_DC);
    assign ic_resp_data  = mem_resp_data;
    assign dc_resp_data  = mem_resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ARB_IDLE;
            rr_ptr              <= SRC_DC;
            lock                <= 1'b0;
            lock_src            <= SRC_DC;
            wr_owner            <= SRC_DC;
            err_unexpected_resp <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    lock     <= mem_req_valid & ~mem_req_ready;
                    lock_src <= winner;
                    if (accept) begin
                        rr_ptr <= other_src(winner);
                        if (win_rw) begin
                            wr_owner <= winner;
                            state    <= ARB_WDATA;
                        end
                    end
                end
                ARB_WDATA: begin
                    lock <= 1'b0;
                    if (data_done) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
            if (mem_resp_valid && fifo_empty) begin
                err_unexpected_resp <= 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept & ~win_rw),
        .push_id (winner),
        .pop     (resp_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding)
    );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed, table-driven bench for cache_mem_arbiter: one table row per clock cycle,
// followed by a short hand-written response-data sequence.
module tb_cache_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam logic [DW-1:0]   IC_BITS = {8{16'h1C1C}};
    localparam logic [DW-1:0]   DC_BITS = {8{16'hDC0D}};
    localparam logic [DW/8-1:0] IC_MASK = 16'h0F0F;
    localparam logic [DW/8-1:0] DC_MASK = 16'hFFFF;

    logic            clk = 1'b0;
    logic            reset;
    logic            ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
    logic [AW-1:0]   ic_req_addr;
    logic [DW-1:0]   ic_req_data_bits, ic_resp_data;
    logic [DW/8-1:0] ic_req_data_mask;
    logic            ic_resp_valid;
    logic            dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
    logic [AW-1:0]   dc_req_addr;
    logic [DW-1:0]   dc_req_data_bits, dc_resp_data;
    logic [DW/8-1:0] dc_req_data_mask;
    logic            dc_resp_valid;
    logic            mem_req_valid, mem_req_ready, mem_req_rw;
    logic            mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_data_bits, mem_resp_data;
    logic [DW/8-1:0] mem_req_data_mask;
    logic [2:0]      outstanding;
    logic            err_unexpected_resp;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .ADDR_BITS       (AW),
        .DATA_BITS       (DW),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ic_req_valid        (ic_req_valid),
        .ic_req_ready        (ic_req_ready),
        .ic_req_addr         (ic_req_addr),
        .ic_req_rw           (ic_req_rw),
        .ic_req_data_valid   (ic_req_data_valid),
        .ic_req_data_ready   (ic_req_data_ready),
        .ic_req_data_bits    (ic_req_data_bits),
        .ic_req_data_mask    (ic_req_data_mask),
        .ic_resp_valid       (ic_resp_valid),
        .ic_resp_data        (ic_resp_data),
        .dc_req_valid        (dc_req_valid),
        .dc_req_ready        (dc_req_ready),
        .dc_req_addr         (dc_req_addr),
        .dc_req_rw           (dc_req_rw),
        .dc_req_data_valid   (dc_req_data_valid),
        .dc_req_data_ready   (dc_req_data_ready),
        .dc_req_data_bits    (dc_req_data_bits),
        .dc_req_data_mask    (dc_req_data_mask),
        .dc_resp_valid       (dc_resp_valid),
        .dc_resp_data        (dc_resp_data),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_addr        (mem_req_addr),
        .mem_req_rw          (mem_req_rw),
        .mem_req_data_valid  (mem_req_data_valid),
        .mem_req_data_ready  (mem_req_data_ready),
        .mem_req_data_bits   (mem_req_data_bits),
        .mem_req_data_mask   (mem_req_data_mask),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_data       (mem_resp_data),
        .outstanding         (outstanding),
        .err_unexpected_resp (err_unexpected_resp)
    );

    typedef struct {
        logic          rst;
        logic          icv;
        logic          icrw;
        logic [AW-1:0] ica;
        logic          dcv;
        logic          dcrw;
        logic [AW-1:0] dca;
        logic          mrdy;
        logic          icdv;
        logic          dcdv;
        logic          mdrdy;
        logic          rspv;
    } in_t;

    typedef struct {
        logic          mv;
        logic [AW-1:0] ma;
        logic          mrw;
        logic          icr;
        logic          dcr;
        logic          dv;
        logic          downer;  // 0 = ic, 1 = dc
        logic          icdr;
        logic          dcdr;
        logic          icrv;
        logic          dcrv;
        logic [2:0]    out;
        logic          err;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic in_t si(input logic rst, input logic icv, input logic icrw,
                               input logic [AW-1:0] ica, input logic dcv, input logic dcrw,
                               input logic [AW-1:0] dca, input logic mrdy, input logic icdv,
                               input logic dcdv, input logic mdrdy, input logic rspv);
        in_t r;
        r.rst = rst; r.icv = icv; r.icrw = icrw; r.ica = ica;
        r.dcv = dcv; r.dcrw = dcrw; r.dca = dca; r.mrdy = mrdy;
        r.icdv = icdv; r.dcdv = dcdv; r.mdrdy = mdrdy; r.rspv = rspv;
        return r;
    endfunction

    function automatic exp_t se(input logic mv, input logic [AW-1:0] ma, input logic mrw,
                                input logic icr, input logic dcr, input logic dv,
                                input logic downer, input logic icdr, input logic dcdr,
                                input logic icrv, input logic dcrv, input logic [2:0] out,
                                input logic err);
        exp_t r;
        r.mv = mv; r.ma = ma; r.mrw = mrw; r.icr = icr; r.dcr = dcr; r.dv = dv;
        r.downer = downer; r.icdr = icdr; r.dcdr = dcdr; r.icrv = icrv; r.dcrv = dcrv;
        r.out = out; r.err = err;
        return r;
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        reset              = i.rst;
        ic_req_valid       = i.icv;
        ic_req_rw          = i.icrw;
        ic_req_addr        = i.ica;
        dc_req_valid       = i.dcv;
        dc_req_rw          = i.dcrw;
        dc_req_addr        = i.dca;
        mem_req_ready      = i.mrdy;
        ic_req_data_valid  = i.icdv;
        dc_req_data_valid  = i.dcdv;
        mem_req_data_ready = i.mdrdy;
        mem_resp_valid     = i.rspv;
    endtask

    task automatic check_row(input int k, input exp_t e);
        check($sformatf("r%0d mem_req_valid", k), DW'(mem_req_valid), DW'(e.mv));
        if (e.mv) begin
            check($sformatf("r%0d mem_req_addr", k), DW'(mem_req_addr), DW'(e.ma));
            check($sformatf("r%0d mem_req_rw", k), DW'(mem_req_rw), DW'(e.mrw));
        end
        check($sformatf("r%0d ic_req_ready", k), DW'(ic_req_ready), DW'(e.icr));
        check($sformatf("r%0d dc_req_ready", k), DW'(dc_req_ready), DW'(e.dcr));
        check($sformatf("r%0d mem_req_data_valid", k), DW'(mem_req_data_valid), DW'(e.dv));
        if (e.dv) begin
            check($sformatf("r%0d mem_req_data_bits", k), mem_req_data_bits,
                  e.downer ? DC_BITS : IC_BITS);
            check($sformatf("r%0d mem_req_data_mask", k), DW'(mem_req_data_mask),
                  DW'(e.downer ? DC_MASK : IC_MASK));
        end
        check($sformatf("r%0d ic_req_data_ready", k), DW'(ic_req_data_ready), DW'(e.icdr));
        check($sformatf("r%0d dc_req_data_ready", k), DW'(dc_req_data_ready), DW'(e.dcdr));
        check($sformatf("r%0d ic_resp_valid", k), DW'(ic_resp_valid), DW'(e.icrv));
        check($sformatf("r%0d dc_resp_valid", k), DW'(dc_resp_valid), DW'(e.dcrv));
        check($sformatf("r%0d outstanding", k), DW'(outstanding), DW'(e.out));
        check($sformatf("r%0d err_unexpected_resp", k), DW'(err_unexpected_resp), DW'(e.err));
    endtask

    task automatic build_table();
        in_t idle;
        in_t rsp;
        in_t both_rd;
        idle    = si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rsp     = si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        both_rd = si(0, 1, 0, 'h100, 1, 0, 'h200, 1, 0, 0, 0, 0);

        // Reset holds every valid/ready low.
        add(si(1, 1, 0, 'h100, 1, 0, 'h200, 1, 0, 0, 0, 0), se(0,0,0,0,0,0,0,0,0,0,0,0,0));
        // Single dc read and its response.
        add(si(0, 0, 0, 0, 1, 0, 'h40, 1, 0, 0, 0, 0), se(1,'h40,0,0,1,0,0,0,0,0,0,0,0));
        add(idle, se(0,0,0,0,0,0,0,0,0,0,0,1,0));
        add(rsp,  se(0,0,0,0,0,0,0,0,0,0,1,1,0));
        add(idle, se(0,0,0,0,0,0,0,0,0,0,0,0,0));
        // Contention from reset: DC, IC, DC, IC, then responses in that order.
        add(si(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), se(0,0,0,0,0,0,0,0,0,0,0,0,0));
        add(both_rd, se(1,'h200,0,0,1,0,0,0,0,0,0,0,0));
        add(both_rd, se(1,'h100,0,1,0,0,0,0,0,0,0,1,0));
        add(both_rd, se(1,'h200,0,0,1,0,0,0,0,0,0,2,0));
        add(both_rd, se(1,'h100,0,1,0,0,0,0,0,0,0,3,0));
        add(rsp, se(0,0,0,0,0,0,0,0,0,0,1,4,0));
        add(rsp, se(0,0,0,0,0,0,0,0,0,1,0,3,0));
        add(rsp, se(0,0,0,0,0,0,0,0,0,0,1,2,0));
        add(rsp, se(0,0,0,0,0,0,0,0,0,1,0,1,0));
        add(idle, se(0,0,0,0,0,0,0,0,0,0,0,0,0));
        // Point rr at IC, then a stalled dc write must keep the grant.
        add(si(0, 0, 0, 0, 1, 0, 'h50, 1, 0, 0, 0, 0), se(1,'h50,0,0,1,0,0,0,0,0,0,0,0));
        add(rsp, se(0,0,0,0,0,0,0,0,0,0,1,1,0));
        add(si(0, 0, 0, 0, 1, 1, 'h10, 0, 0, 1, 0, 0), se(1,'h10,1,0,0,0,0,0,0,0,0,0,0));
        add(si(0, 1, 0, 'h300, 1, 1, 'h10, 0, 0, 1, 0, 0), se(1,'h10,1,0,0,0,0,0,0,0,0,0,0));
        add(si(0, 1, 0, 'h300, 1, 1, 'h10, 0, 0, 1, 0, 0), se(1,'h10,1,0,0,0,0,0,0,0,0,0,0));
        add(si(0, 1, 0, 'h300, 1, 1, 'h10, 1, 0, 1, 0, 0), se(1,'h10,1,0,1,0,0,0,0,0,0,0,0));
        add(si(0, 1, 0, 'h300, 0, 0, 0, 1, 0, 1, 0, 0), se(0,0,0,0,0,1,1,0,0,0,0,0,0));
        add(si(0, 1, 0, 'h300, 0, 0, 0, 1, 0, 1, 0, 0), se(0,0,0,0,0,1,1,0,0,0,0,0,0));
        add(si(0, 1, 0, 'h300, 0, 0, 0, 1, 0, 1, 1, 0), se(0,0,0,0,0,1,1,0,1,0,0,0,0));
        add(si(0, 1, 0, 'h300, 0, 0, 0, 1, 0, 0, 0, 0), se(1,'h300,0,1,0,0,0,0,0,0,0,0,0));
        add(rsp, se(0,0,0,0,0,0,0,0,0,1,0,1,0));
        // Fill the FIFO with four ic reads.
        for (int k = 0; k < 4; k++) begin
            add(si(0, 1, 0, AW'('h400 + k), 0, 0, 0, 1, 0, 0, 0, 0),
                se(1, AW'('h400 + k), 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'(k), 0));
        end
        add(si(0, 1, 0, 'h404, 0, 0, 0, 1, 0, 0, 0, 0), se(0,0,0,0,0,0,0,0,0,0,0,4,0));
        add(si(0, 1, 0, 'h404, 1, 1, 'h20, 1, 0, 0, 0, 0), se(1,'h20,1,0,1,0,0,0,0,0,0,4,0));
        add(si(0, 1, 0, 'h404, 0, 0, 0, 1, 0, 1, 1, 0), se(0,0,0,0,0,1,1,0,1,0,0,4,0));
        // IC wins but is gated; the dc write must not be promoted.
        add(si(0, 1, 0, 'h404, 1, 1, 'h30, 1, 0, 0, 0, 0), se(0,0,0,0,0,0,0,0,0,0,0,4,0));
        // Full with a same-cycle response: blocked now, accepted next cycle.
        add(si(0, 1, 0, 'h404, 0, 0, 0, 1, 0, 0, 0, 1), se(0,0,0,0,0,0,0,0,0,1,0,4,0));
        add(si(0, 1, 0, 'h404, 0, 0, 0, 1, 0, 0, 0, 0), se(1,'h404,0,1,0,0,0,0,0,0,0,3,0));
        for (int k = 4; k > 0; k--) begin
            add(rsp, se(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'(k), 0));
        end
        add(idle, se(0,0,0,0,0,0,0,0,0,0,0,0,0));
        // Push and pop in one cycle leave occupancy unchanged.
        add(si(0, 1, 0, 'h500, 0, 0, 0, 1, 0, 0, 0, 0), se(1,'h500,0,1,0,0,0,0,0,0,0,0,0));
        add(si(0, 1, 0, 'h501, 0, 0, 0, 1, 0, 0, 0, 1), se(1,'h501,0,1,0,0,0,0,0,1,0,1,0));
        add(rsp, se(0,0,0,0,0,0,0,0,0,1,0,1,0));
        // Spurious response sets the sticky error.
        add(rsp,  se(0,0,0,0,0,0,0,0,0,0,0,0,0));
        add(idle, se(0,0,0,0,0,0,0,0,0,0,0,0,1));
        add(idle, se(0,0,0,0,0,0,0,0,0,0,0,0,1));
        // Reset during WDATA with two reads outstanding.
        add(si(0, 0, 0, 0, 1, 0, 'h600, 1, 0, 0, 0, 0), se(1,'h600,0,0,1,0,0,0,0,0,0,0,1));
        add(si(0, 1, 0, 'h601, 0, 0, 0, 1, 0, 0, 0, 0), se(1,'h601,0,1,0,0,0,0,0,0,0,1,1));
        add(si(0, 0, 0, 0, 1, 1, 'h40, 1, 0, 0, 0, 0), se(1,'h40,1,0,1,0,0,0,0,0,0,2,1));
        add(si(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), se(0,0,0,0,0,1,1,0,0,0,0,2,1));
        add(si(1, 1, 0, 'h100, 1, 0, 'h200, 1, 1, 1, 1, 1), se(0,0,0,0,0,0,0,0,0,0,0,2,1));
        add(si(1, 1, 0, 'h100, 1, 0, 'h200, 1, 1, 1, 1, 1), se(0,0,0,0,0,0,0,0,0,0,0,0,0));
        add(rsp, se(0,0,0,0,0,0,0,0,0,0,0,0,0));
        add(si(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), se(0,0,0,0,0,0,0,0,0,0,0,0,1));
        // ic write carries the ic data and mask.
        add(si(0, 1, 1, 'h70, 0, 0, 0, 1, 0, 0, 0, 0), se(1,'h70,1,1,0,0,0,0,0,0,0,0,1));
        add(si(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0), se(0,0,0,0,0,1,0,1,0,0,0,0,1));
        add(idle, se(0,0,0,0,0,0,0,0,0,0,0,0,1));
    endtask

    initial begin
        ic_req_data_bits = IC_BITS;
        ic_req_data_mask = IC_MASK;
        dc_req_data_bits = DC_BITS;
        dc_req_data_mask = DC_MASK;
        mem_resp_data    = '0;
        drive(si(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;

        build_table();
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].i);
            @(negedge clk);
            check_row(k, vecs[k].e);
            @(posedge clk);
            #1;
        end

        // Response data is broadcast and steered by the recorded source.
        drive(si(0, 0, 0, 0, 1, 0, 'h7A0, 1, 0, 0, 0, 0));
        @(negedge clk);
        check("hand dc_req_ready", DW'(dc_req_ready), DW'(1'b1));
        @(posedge clk);
        #1;
        drive(si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        mem_resp_data = {4{32'hA5C3_0F96}};
        @(negedge clk);
        check("hand dc_resp_valid", DW'(dc_resp_valid), DW'(1'b1));
        check("hand ic_resp_valid", DW'(ic_resp_valid), DW'(1'b0));
        check("hand dc_resp_data", dc_resp_data, {4{32'hA5C3_0F96}});
        check("hand ic_resp_data", ic_resp_data, {4{32'hA5C3_0F96}});
        @(posedge clk);
        #1;
        drive(si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("hand outstanding", DW'(outstanding), DW'(3'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits between the instruction cache, the data cache and the single main-memory port.
- Both caches use the identical mem_req/mem_resp protocol: address handshake, separate write-data handshake, and an in-order read response.
- The block round-robin arbitrates address requests and sequences the write-data beat for an accepted write.
- It records the source of every accepted read in an in-order FIFO and steers each mem_resp_valid beat back to the cache that issued it.

Parameters:
- ADDR_BITS, 28, line address width (`CPU_ADDR_BITS - ceilLog2(`MEM_DATA_BITS/8)).
- DATA_BITS, 128, memory beat width (`MEM_DATA_BITS).
- MAX_OUTSTANDING, 4, maximum number of accepted reads awaiting a response (power of two, 2..16).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- Per-cache port set, for X in {ic, dc}, all widths relative to the cache:
  - X_req_valid  in  1
  - X_req_ready  out  1
  - X_req_addr  in  ADDR_BITS
  - X_req_rw  in  1
  - X_req_data_valid  in  1
  - X_req_data_ready  out  1
  - X_req_data_bits  in  DATA_BITS
  - X_req_data_mask  in  DATA_BITS/8
  - X_resp_valid  out  1
  - X_resp_data  out  DATA_BITS
- Memory side:
  - mem_req_valid  out  1
  - mem_req_ready  in  1
  - mem_req_addr  out  ADDR_BITS
  - mem_req_rw  out  1
  - mem_req_data_valid  out  1
  - mem_req_data_ready  in  1
  - mem_req_data_bits  out  DATA_BITS
  - mem_req_data_mask  out  DATA_BITS/8
  - mem_resp_valid  in  1
  - mem_resp_data  in  DATA_BITS
- Status:
  - outstanding  out  clog2(MAX_OUTSTANDING)+1  current read-FIFO occupancy.
  - err_unexpected_resp  out  1  sticky; set by a response arriving while the FIFO is empty.

Behaviour:
- Reset:
  - state=IDLE, rr_ptr=DC (dcache wins the first tie), FIFO empty, lock clear, err_unexpected_resp=0.
  - All valid/ready outputs are 0 while reset is high.
- State machine IDLE / WDATA:
  - IDLE:
    - Winner selection: only one requester valid -> that requester wins. Both valid -> the rr_ptr side wins.
    - Address forwarding is combinational, zero latency: mem_req_valid/addr/rw = winner's, winner's X_req_ready = mem_req_ready. The loser's ready = 0.
    - Read gating: if the winner's request is a read and the FIFO is full, mem_req_valid=0 and ready=0. The loser is NOT promoted.
  - Grant lock:
    - If mem_req_valid=1 and mem_req_ready=0, the winner is latched.
    - The lock holds until the handshake completes, even if the other side becomes valid.
  - Accept (valid&ready):
    - rr_ptr moves to the other cache.
    - Read: push the source id.
    - Write: record the owner and go to WDATA the next cycle.
  - WDATA:
    - No address accepted; both X_req_ready=0.
    - mem_req_data_valid/bits/mask = the owner's. Owner's X_req_data_ready = mem_req_data_ready; the other side's = 0.
    - Data handshake -> IDLE the next cycle.
    - Write data is never forwarded in IDLE (data_ready=0 there), even if a cache raises data_valid together with req_valid.
- Response path:
  - X_resp_data = mem_resp_data, broadcast to both caches.
  - X_resp_valid = mem_resp_valid & FIFO non-empty & head==X. The beat pops the FIFO the same cycle.
  - mem_resp_valid with an empty FIFO: the beat is dropped and err_unexpected_resp is set.
  - Writes produce no response entry.
- FIFO occupancy:
  - A push and a pop in the same cycle are legal (occupancy unchanged) when not full.
  - When full, a pop in the same cycle does not enable a push (the full check uses registered occupancy).
  - Pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation:
  - WDATA is abandoned and the FIFO is cleared.
  - Responses to pre-reset reads are treated as unexpected.

Decomposition:
- const.vh gains:
  - `MEM_ADDR_BITS
  - `ARB_SRC_IC=1'b0, `ARB_SRC_DC=1'b1
  - state encodings ARB_IDLE, ARB_WDATA
- Sub-module arb_id_fifo: 1-bit wide, MAX_OUTSTANDING deep, synchronous reset, with push/pop/full/empty/count.

Test Plan:
- Single-sided traffic: dc read 0x0000040 alone, mem_req_ready=1 -> mem_req_addr=0x0000040 and rw=0 the same cycle. A response 2 cycles later -> dc_resp_valid=1, ic_resp_valid=0, outstanding returns to 0.
- Simultaneous contention: ic and dc both valid reads every cycle after reset -> grants alternate DC, IC, DC, IC. Responses return to the caches in the same order.
- Stall and write sequencing:
  - dc write 0x10 with mem_req_ready=0 for 3 cycles while ic also becomes valid -> the grant stays with dc.
  - After the accept: WDATA, with data_ready low 2 cycles -> ic_req_ready=0 throughout. The data beat carries mask 0xFFFF, then IDLE and ic is granted.
- Outstanding limit: 4 ic reads accepted with no responses -> the 5th read has mem_req_valid=0, while a dc write is still forwarded. One response -> the 5th read is accepted.
- Full-FIFO boundary:
  - At full, a same-cycle response and a new read -> the read is blocked that cycle and accepted the next.
  - A spurious response with the FIFO empty -> err_unexpected_resp=1 and remains 1.
- Reset mid-operation: reset asserted in WDATA with 2 outstanding reads -> all readies and valids are 0, outstanding=0. A later response sets err_unexpected_resp.
